counter_modk_cascade: RTL

Parametrised cascade of DIGITS mod-K counter stages, each W bits wide, forming one multi-digit counter. Used for multi-digit decimal and time displays, e.g. K=10 for BCD digits and K=6 for tens of seconds. Adds the following over a single mod-k stage:
- up/down counting
- count enable
- synchronous clear and parallel load
- ripple-free internal carry between digits
- terminal-count output for chaining multiple instances
- registered whole-chain roll-over pulse

---
 rtl/counter_modk_cascade.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/counter_modk_cascade.sv
// counter_modk_cascade
//   Cascade of DIGITS mod-K digit counters, each W bits wide, forming one
//   multi-digit counter (e.g. K=10 for BCD displays, K=6 for tens of seconds).
//   Features: up/down counting, count enable (doubles as carry-in when
//   instances are chained), synchronous clear and clamped parallel load,
//   single-cycle carry across all digits, combinational terminal count (tc)
//   and a registered whole-chain roll-over pulse.
//
//   Optional build macro COUNTER_SAT_EN:
//     defined   - the chain saturates at all K-1 (up) / all 0 (down) instead
//                 of wrapping; roll_over flags each suppressed step.
//     undefined - wrap-around counting.
module counter_modk_cascade #(
    parameter int W      = 4,
    parameter int K      = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  rst_neg,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [DIGITS*W-1:0]   load_val,
    output logic [DIGITS*W-1:0]   Q,
    output logic                  tc,
    output logic                  roll_over
);

    // Modulus widened by one bit so K = 2^W is representable.
    localparam logic [W:0]   K_EXT = (W+1)'(K);
    localparam logic [W-1:0] TOP   = W'(K - 1);
    localparam logic [W-1:0] ONE   = W'(1);

    logic [W-1:0]      digit_q [DIGITS];
    logic [W-1:0]      digit_d [DIGITS];
    logic [W-1:0]      load_d  [DIGITS];
    logic [DIGITS-1:0] t;
    logic [DIGITS-1:0] c;
    logic              step_ok;

    // Load values at or above the modulus are clamped to the top digit value.
    function automatic logic [W-1:0] clamp_digit(input logic [W-1:0] v);
        if ({1'b0, v} >= K_EXT)
            return TOP;
        else
            return v;
    endfunction

    // Per-digit terminal condition: K-1 when counting up, 0 when counting down.
    always_comb begin
        t = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (up)
                t[i] = (digit_q[i] == TOP);
            else
                t[i] = (digit_q[i] == '0);
        end
    end

    // Carry chain resolved in a single cycle; a running AND keeps the
    // vector free of self-referencing bit dependencies.
    always_comb begin
        logic run;
        run = en;
        c   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            c[i] = run;
            run  = run & t[i];
        end
        tc = run;
    end

    // Whole-chain step qualifier: saturating builds block the step at terminal count.
    always_comb begin
`ifdef COUNTER_SAT_EN
        step_ok = ~tc;
`else
        step_ok = 1'b1;
`endif
    end

    // Next value of each digit when counting.
    always_comb begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit_d[i] = digit_q[i];
            if (c[i] && step_ok) begin
                if (up)
                    digit_d[i] = t[i] ? '0 : digit_q[i] + ONE;
                else
                    digit_d[i] = t[i] ? TOP : digit_q[i] - ONE;
            end
        end
    end

    // Unpack and clamp the parallel load word.
    always_comb begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
            load_d[i] = clamp_digit(load_val[i*W +: W]);
        end
    end

    // Digit registers: clear beats load beats count.
    always_ff @(posedge clock or negedge rst_neg) begin
        if (!rst_neg) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                digit_q[i] <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                digit_q[i] <= '0;
            end
        end else if (load) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                digit_q[i] <= load_d[i];
            end
        end else begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                digit_q[i] <= digit_d[i];
            end
        end
    end

    // Roll-over pulse: registered tc, suppressed by clear or load.
    always_ff @(posedge clock or negedge rst_neg) begin
        if (!rst_neg)
            roll_over <= 1'b0;
        else if (clr || load)
            roll_over <= 1'b0;
        else
            roll_over <= tc;
    end

    // Pack digits onto the output bus, digit 0 in the low bits.
    always_comb begin
        Q = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            Q[i*W +: W] = digit_q[i];
        end
    end

endmodule
